// File: rtl/game_pkg.sv
// Purpose: shared state/mode encodings, sync-byte constants and counter width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  // Encodings of the original states are unchanged; LINK_LOST takes the next free code.
  typedef enum logic [2:0] {
    START     = 3'd0,
    KEEPER    = 3'd1,
    SHOOTER   = 3'd2,
    WINNER    = 3'd3,
    LOSER     = 3'd4,
    LINK_LOST = 3'd5
  } g_state;

  typedef enum logic {
    MULTI = 1'b0,
    SOLO  = 1'b1
  } g_mode;

  localparam logic [7:0] TX_LEFT  = 8'hC8;
  localparam logic [7:0] TX_RIGHT = 8'h28;
  localparam logic [7:0] TX_START = 8'h48;
  localparam logic [7:0] TX_IDLE  = 8'h08;

  // Width able to hold 0..max; never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/game_state_ctrl_sat_counter.sv
// Purpose: up-counter that holds at MAX, with synchronous clear taking priority.
// Latency: 1 cycle from clr/en to out; at_max is combinational from the register.
// Backpressure: none; en is ignored once MAX is reached.
// Ports: clk, rst_n (async active-low), clr, en in; out (count), at_max (out==MAX) out.
module sat_counter
  import game_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] out,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == W'(MAX));
  assign out    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Purpose: penalty-game flow FSM: mode select, link settle/loss recovery, result screens, round count.
// Latency: 1 cycle; every output is registered and reflects the previous cycle's inputs.
// Backpressure: none; inputs are single-cycle pulses/levels, outputs are never stalled.
// Ports: clk, rst_n, mouse pulses, solo_enable, link/peer flags, score events in;
//        data_to_transmit, game_state, game_mode, round_num, state_changed out.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int SYNC_CYCLES  = 1_000_000,
  parameter int LINK_TIMEOUT = 50_000_000,
  parameter int RESULT_HOLD  = 0,
  parameter int ROUND_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               left_clicked,
  input  logic               right_clicked,
  input  logic               solo_enable,
  input  logic               connect_corrected,
  input  logic               enemy_shooter,
  input  logic               game_starts,
  input  logic               match_end,
  input  logic               match_result,
  input  logic               end_gk,
  input  logic               end_sh,
  input  logic               back_to_start,
  output logic [7:0]         data_to_transmit,
  output g_state             game_state,
  output g_mode              game_mode,
  output logic [ROUND_W-1:0] round_num,
  output logic               state_changed
);

  localparam int SYNC_W = cnt_w(SYNC_CYCLES);
  localparam int LOSS_W = cnt_w(LINK_TIMEOUT);
  localparam int HOLD_W = cnt_w(RESULT_HOLD);

  g_state               state_q, state_d;
  g_state               prev_q, prev_d;
  g_mode                mode_q, mode_d;
  logic [7:0]           tx_q, tx_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 changed_q, changed_d;

  logic [SYNC_W-1:0]    sync_cnt;
  logic [LOSS_W-1:0]    loss_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 sync_at_max, loss_at_max, hold_at_max;
  logic                 sync_clr, loss_clr, hold_clr;
  logic                 loss_done, hold_done, swap;

  // Settle counter only runs while sitting in START in multiplayer with the link up;
  // the other two run only inside their state, so each restarts from 0 on entry.
  assign sync_clr = !((state_q == START) && (mode_d == MULTI) && connect_corrected);
  assign loss_clr = (state_q != LINK_LOST);
  assign hold_clr = !((state_q == WINNER) || (state_q == LOSER));

  sat_counter #(.MAX(SYNC_CYCLES), .W(SYNC_W)) u_sync_cnt (
    .clk(clk), .rst_n(rst_n), .clr(sync_clr), .en(1'b1), .out(sync_cnt), .at_max(sync_at_max)
  );
  sat_counter #(.MAX(LINK_TIMEOUT), .W(LOSS_W)) u_loss_cnt (
    .clk(clk), .rst_n(rst_n), .clr(loss_clr), .en(1'b1), .out(loss_cnt), .at_max(loss_at_max)
  );
  sat_counter #(.MAX(RESULT_HOLD), .W(HOLD_W)) u_hold_cnt (
    .clk(clk), .rst_n(rst_n), .clr(hold_clr), .en(1'b1), .out(hold_cnt), .at_max(hold_at_max)
  );

  assign loss_done = (loss_cnt == LOSS_W'(LINK_TIMEOUT - 1));
  // RESULT_HOLD==0 disables the auto-return entirely.
  assign hold_done = (RESULT_HOLD != 0) && (hold_cnt == HOLD_W'(RESULT_HOLD - 1));

  // Raw count and flags not needed for decisions; folded here so they stay observable.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{sync_cnt, loss_at_max, hold_at_max};

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    // Mode follows the switch only in START; decisions in START use the live switch.
    mode_d  = (state_q == START) ? (solo_enable ? SOLO : MULTI) : mode_q;

    unique case (state_q)
      START: begin
        if (mode_d == SOLO) begin
          if (left_clicked) state_d = KEEPER;
        end else if (game_starts && sync_at_max) begin
          state_d = enemy_shooter ? SHOOTER : KEEPER;
        end
      end
      KEEPER, SHOOTER: begin
        if (match_end) begin
          state_d = match_result ? WINNER : LOSER;
        end else if ((mode_q == MULTI) && !connect_corrected) begin
          state_d = LINK_LOST;
          prev_d  = state_q;
        end else if ((state_q == KEEPER) && end_gk) begin
          state_d = SHOOTER;
        end else if ((state_q == SHOOTER) && end_sh) begin
          state_d = KEEPER;
        end
      end
      LINK_LOST: begin
        if (connect_corrected) state_d = prev_q;
        else if (loss_done)    state_d = START;
      end
      WINNER, LOSER: begin
        if (right_clicked || (back_to_start && (mode_q == MULTI)) || hold_done) begin
          state_d = START;
        end
      end
      default: state_d = START;
    endcase

    if (left_clicked)       tx_d = TX_LEFT;
    else if (right_clicked) tx_d = TX_RIGHT;
    else if (game_starts)   tx_d = TX_START;
    else                    tx_d = TX_IDLE;

    swap    = ((state_q == KEEPER) && (state_d == SHOOTER)) ||
              ((state_q == SHOOTER) && (state_d == KEEPER));
    round_d = round_q;
    if (state_d == START) begin
      round_d = '0;
    end else if (swap && (round_q != '1)) begin
      round_d = round_q + 1'b1;
    end

    changed_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= START;
      prev_q    <= KEEPER;
      mode_q    <= MULTI;
      tx_q      <= 8'h00;
      round_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      round_q   <= round_d;
      changed_q <= changed_d;
    end
  end

  assign game_state       = state_q;
  assign game_mode        = mode_q;
  assign data_to_transmit = tx_q;
  assign round_num        = round_q;
  assign state_changed    = changed_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Purpose: directed scenarios followed by random traffic, all outputs compared every cycle
//          against a cycle-indexed behavioural model of the game rules.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int SYNC = 4;
  localparam int LT   = 10;
  localparam int RH   = 6;
  localparam int RW   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic left_clicked = 0, right_clicked = 0, solo_enable = 0, connect_corrected = 0;
  logic enemy_shooter = 0, game_starts = 0, match_end = 0, match_result = 0;
  logic end_gk = 0, end_sh = 0, back_to_start = 0;

  logic [7:0]    data_to_transmit;
  g_state        game_state;
  g_mode         game_mode;
  logic [RW-1:0] round_num;
  logic          state_changed;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .SYNC_CYCLES(SYNC), .LINK_TIMEOUT(LT), .RESULT_HOLD(RH), .ROUND_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .left_clicked(left_clicked), .right_clicked(right_clicked),
    .solo_enable(solo_enable), .connect_corrected(connect_corrected),
    .enemy_shooter(enemy_shooter), .game_starts(game_starts),
    .match_end(match_end), .match_result(match_result),
    .end_gk(end_gk), .end_sh(end_sh), .back_to_start(back_to_start),
    .data_to_transmit(data_to_transmit), .game_state(game_state),
    .game_mode(game_mode), .round_num(round_num), .state_changed(state_changed)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: rules expressed with cycle stamps rather than counters.
  g_state m_state, m_prev;
  g_mode  m_mode;
  int     m_tx, m_round, m_cyc, m_entry, up_since;
  bit     m_changed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = START; m_prev = KEEPER; m_mode = MULTI;
    m_tx = 0; m_round = 0; m_changed = 0;
    m_entry = m_cyc; up_since = -1;
  endtask

  // Apply the rules to the inputs present during cycle m_cyc.
  task automatic model_step();
    g_state nx;
    g_mode  md;
    int     in_state;
    bit     settled, swap;
    in_state = m_cyc - m_entry;
    settled  = (up_since >= 0) && ((m_cyc - up_since) >= SYNC);
    md = (m_state == START) ? (solo_enable ? SOLO : MULTI) : m_mode;
    nx = m_state;
    case (m_state)
      START:
        if (md == SOLO) begin
          if (left_clicked) nx = KEEPER;
        end else if (game_starts && settled) nx = enemy_shooter ? SHOOTER : KEEPER;
      KEEPER, SHOOTER:
        if (match_end) nx = match_result ? WINNER : LOSER;
        else if (m_mode == MULTI && !connect_corrected) begin nx = LINK_LOST; m_prev = m_state; end
        else if (m_state == KEEPER && end_gk) nx = SHOOTER;
        else if (m_state == SHOOTER && end_sh) nx = KEEPER;
      LINK_LOST:
        if (connect_corrected) nx = m_prev;
        else if (in_state == LT - 1) nx = START;
      default:
        if (right_clicked || (back_to_start && m_mode == MULTI) || (RH != 0 && in_state == RH - 1))
          nx = START;
    endcase
    if (m_state == START && md == MULTI && connect_corrected) begin
      if (up_since < 0) up_since = m_cyc;
    end else begin
      up_since = -1;
    end
    swap = (m_state == KEEPER && nx == SHOOTER) || (m_state == SHOOTER && nx == KEEPER);
    if (nx == START) m_round = 0;
    else if (swap && m_round < (2**RW) - 1) m_round = m_round + 1;
    m_tx = left_clicked ? 8'hC8 : right_clicked ? 8'h28 : game_starts ? 8'h48 : 8'h08;
    m_changed = (nx != m_state);
    if (m_changed) m_entry = m_cyc + 1;
    m_state = nx;
    m_mode  = md;
    m_cyc++;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".state"},   32'(game_state),       32'(m_state));
    chk({tag, ".mode"},    32'(game_mode),        32'(m_mode));
    chk({tag, ".tx"},      32'(data_to_transmit), 32'(m_tx));
    chk({tag, ".round"},   32'(round_num),        32'(m_round));
    chk({tag, ".changed"}, 32'(state_changed),    32'(m_changed));
    left_clicked = 0; right_clicked = 0; game_starts = 0; match_end = 0;
    end_gk = 0; end_sh = 0; back_to_start = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".state"},   32'(game_state),       32'(START));
    chk({tag, ".mode"},    32'(game_mode),        32'(MULTI));
    chk({tag, ".tx"},      32'(data_to_transmit), 32'h00);
    chk({tag, ".round"},   32'(round_num),        32'd0);
    chk({tag, ".changed"}, 32'(state_changed),    32'd0);
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();

    step("idle");
    chk("idle_tx", 32'(data_to_transmit), 32'h08);
    chk("idle_state", 32'(game_state), 32'(START));

    // SOLO round trip
    solo_enable = 1; left_clicked = 1; step("solo_go");
    chk("solo_keeper", 32'(game_state), 32'(KEEPER));
    chk("solo_mode", 32'(game_mode), 32'(SOLO));
    chk("solo_strobe", 32'(state_changed), 32'd1);
    end_gk = 1; step("solo_gk");
    chk("solo_shooter", 32'(game_state), 32'(SHOOTER));
    end_sh = 1; step("solo_sh");
    chk("solo_round2", 32'(round_num), 32'd2);
    step("solo_linkdown");
    chk("solo_link_ignored", 32'(game_state), 32'(KEEPER));
    chk("solo_strobe_low", 32'(state_changed), 32'd0);
    match_end = 1; match_result = 1; step("solo_win");
    chk("solo_winner", 32'(game_state), 32'(WINNER));
    chk("solo_round_kept", 32'(round_num), 32'd2);
    right_clicked = 1; step("solo_back");
    chk("solo_start", 32'(game_state), 32'(START));
    chk("solo_round0", 32'(round_num), 32'd0);

    // MULTI settle
    solo_enable = 0; step("to_multi");
    chk("multi_mode", 32'(game_mode), 32'(MULTI));
    connect_corrected = 1; step("settle1");
    game_starts = 1; step("settle2_early");
    chk("early_start_ignored", 32'(game_state), 32'(START));
    chk("tx_start", 32'(data_to_transmit), 32'h48);
    connect_corrected = 0; step("settle_drop");
    connect_corrected = 1;
    repeat (3) step("settle_up");
    game_starts = 1; enemy_shooter = 1; step("settle_3");
    chk("unsaturated_ignored", 32'(game_state), 32'(START));
    game_starts = 1; step("settle_4");
    chk("multi_shooter", 32'(game_state), 32'(SHOOTER));

    // rounds, then link loss recovery
    end_sh = 1; step("r1"); end_gk = 1; step("r2");
    end_sh = 1; step("r3"); end_gk = 1; step("r4");
    chk("round4", 32'(round_num), 32'd4);
    connect_corrected = 0; step("loss_enter");
    chk("link_lost", 32'(game_state), 32'(LINK_LOST));
    match_end = 1; end_sh = 1; step("loss_ignore");
    chk("loss_ignores_events", 32'(game_state), 32'(LINK_LOST));
    repeat (3) step("loss_wait");
    connect_corrected = 1; step("loss_recover");
    chk("recover_shooter", 32'(game_state), 32'(SHOOTER));
    chk("recover_round", 32'(round_num), 32'd4);

    // round saturation at all-ones
    end_sh = 1; step("r5"); end_gk = 1; step("r6");
    end_sh = 1; step("r7"); end_gk = 1; step("r8");
    chk("round_sat", 32'(round_num), 32'd7);

    // link timeout
    connect_corrected = 0; step("to_enter");
    repeat (9) step("to_wait");
    chk("to_before", 32'(game_state), 32'(LINK_LOST));
    step("to_fire");
    chk("to_start", 32'(game_state), 32'(START));
    chk("to_round0", 32'(round_num), 32'd0);
    chk("to_strobe", 32'(state_changed), 32'd1);

    // simultaneous events in KEEPER, then result hold
    connect_corrected = 1;
    repeat (4) step("k_settle");
    game_starts = 1; enemy_shooter = 0; step("k_go");
    chk("multi_keeper", 32'(game_state), 32'(KEEPER));
    match_end = 1; match_result = 0; end_gk = 1; connect_corrected = 0; step("simul");
    chk("simul_loser", 32'(game_state), 32'(LOSER));
    connect_corrected = 1;
    repeat (5) step("hold");
    chk("hold_before", 32'(game_state), 32'(LOSER));
    step("hold_fire");
    chk("hold_start", 32'(game_state), 32'(START));

    // sync byte priority, peer back_to_start
    left_clicked = 1; right_clicked = 1; step("tx_both");
    chk("tx_both", 32'(data_to_transmit), 32'hC8);
    right_clicked = 1; step("tx_right");
    chk("tx_right", 32'(data_to_transmit), 32'h28);
    repeat (2) step("b_settle");
    game_starts = 1; step("b_go");
    match_end = 1; match_result = 1; step("b_win");
    back_to_start = 1; step("b_back");
    chk("peer_back", 32'(game_state), 32'(START));

    // back_to_start ignored in SOLO
    solo_enable = 1; left_clicked = 1; step("s_go");
    match_end = 1; step("s_win");
    back_to_start = 1; step("s_back");
    chk("solo_back_ignored", 32'(game_state), 32'(WINNER));
    right_clicked = 1; step("s_exit");

    // async reset mid-cycle
    left_clicked = 1; step("ar_go");
    end_gk = 1; step("ar_gk");
    #3;
    rst_n = 0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("held_rst");
    solo_enable = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if (i % 300 == 0) solo_enable = ($urandom_range(0, 3) == 0);
      if (connect_corrected) begin
        if ($urandom_range(0, 99) < 3) connect_corrected = 0;
      end else if ($urandom_range(0, 99) < 20) begin
        connect_corrected = 1;
      end
      left_clicked  = ($urandom_range(0, 99) < 10);
      right_clicked = ($urandom_range(0, 99) < 5);
      game_starts   = ($urandom_range(0, 99) < 15);
      enemy_shooter = ($urandom_range(0, 1) == 1);
      match_end     = ($urandom_range(0, 99) < 3);
      match_result  = ($urandom_range(0, 1) == 1);
      end_gk        = ($urandom_range(0, 99) < 15);
      end_sh        = ($urandom_range(0, 99) < 15);
      back_to_start = ($urandom_range(0, 99) < 5);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
